// File: rtl/combo_pkg.sv
// Shared types and constants for the combo2 sweep controller.
// No logic; the golden table is the truth table of o = ~((a&b)|(c^d)).
// Bit k of a table is o for {a,b,c,d} = k.
package combo_pkg;

    localparam int VEC_W   = 4;
    localparam int TABLE_W = 16;

    localparam logic [TABLE_W-1:0] COMBO2_GOLDEN = 16'h0999;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        APPLY  = 3'd1,
        SETTLE = 3'd2,
        SAMPLE = 3'd3,
        DONE   = 3'd4
    } state_e;

endpackage

// File: rtl/combo2_sweep_ctrl.sv
// Sweeps all 16 {a,b,c,d} vectors into an external 4-input function and captures its truth table.
// Latency: 2+SETTLE_CYCLES cycles per vector; done is high 16*(2+SETTLE_CYCLES)+1 cycles after start is sampled.
// No backpressure; abort cancels a sweep. Optional first-failure capture under COMBO_SWEEP_FIRSTFAIL_EN.
module combo2_sweep_ctrl
    import combo_pkg::*;
#(
    parameter int                 SETTLE_CYCLES  = 1,
    parameter logic [TABLE_W-1:0] EXPECTED_TABLE = COMBO2_GOLDEN
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 fn_o,
    output logic [VEC_W-1:0]     vec_out,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
`ifdef COMBO_SWEEP_FIRSTFAIL_EN
    output logic                 fail_valid,
    output logic [VEC_W-1:0]     first_fail_idx,
`endif
    output logic [TABLE_W-1:0]   truth_table
);

    localparam logic [7:0] SETTLE_INIT = 8'(SETTLE_CYCLES);

    state_e             state;
    logic [VEC_W-1:0]   idx;
    logic [7:0]         settle_cnt;
    logic [TABLE_W-1:0] table_next;

    // Table as it will look once the current sample lands; lets pass be valid in the same cycle as done.
    always_comb begin
        table_next      = truth_table;
        table_next[idx] = fn_o;
    end

    assign busy = (state == APPLY) || (state == SETTLE) || (state == SAMPLE);

    // Sweep sequencer: vector drive, settle countdown, sample capture and verdict.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            idx         <= '0;
            settle_cnt  <= '0;
            vec_out     <= '0;
            done        <= 1'b0;
            pass        <= 1'b0;
            truth_table <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        idx         <= '0;
                        truth_table <= '0;
                        pass        <= 1'b0;
                        state       <= APPLY;
                    end
                end
                APPLY: begin
                    if (abort) begin
                        pass  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        vec_out    <= idx;
                        settle_cnt <= SETTLE_INIT;
                        state      <= (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;
                    end
                end
                SETTLE: begin
                    if (abort) begin
                        pass  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        settle_cnt <= settle_cnt - 8'd1;
                        if (settle_cnt <= 8'd1) begin
                            state <= SAMPLE;
                        end
                    end
                end
                SAMPLE: begin
                    if (abort) begin
                        pass  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        truth_table <= table_next;
                        if (idx == VEC_W'(TABLE_W - 1)) begin
                            // Last vector: finish rather than letting idx wrap to 0.
                            done  <= 1'b1;
                            pass  <= (table_next == EXPECTED_TABLE);
                            state <= DONE;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= APPLY;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef COMBO_SWEEP_FIRSTFAIL_EN
    // Latch the index of the first sample that disagrees with the golden table.
    always_ff @(posedge clk) begin
        if (rst) begin
            fail_valid     <= 1'b0;
            first_fail_idx <= '0;
        end else if (state == IDLE && start) begin
            fail_valid     <= 1'b0;
            first_fail_idx <= '0;
        end else if (state == SAMPLE && !abort && !fail_valid
                     && (fn_o != EXPECTED_TABLE[idx])) begin
            fail_valid     <= 1'b1;
            first_fail_idx <= idx;
        end
    end
`endif

endmodule

// File: tb/tb_combo2_sweep_ctrl.sv
// Bench for combo2_sweep_ctrl: three instances (settle 1, 0, 3) each driving a behavioural model of o.
// Expected sweep results are queued when start is driven and checked when done pulses.
// Define COMBO_SWEEP_FIRSTFAIL_EN on both bench and RTL to cover the first-failure outputs.
module tb_combo2_sweep_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] start_v;
    logic       abort;
    int         mode;

    logic [3:0]  vec0, vec1, vec3;
    logic        busy0, busy1, busy3, done0, done1, done3, pass0, pass1, pass3;
    logic [15:0] tab0, tab1, tab3;
    logic        fn0, fn1, fn3;
`ifdef COMBO_SWEEP_FIRSTFAIL_EN
    logic       fv0, fv1, fv3;
    logic [3:0] ff0, ff1, ff3;
`endif

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [15:0] tab;
        logic        pass;
        int          cyc;
        logic        fvalid;
        logic [3:0]  fidx;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    // Behavioural o = ~((a&b)|(c^d)); mode 1 ties it low, mode 2 flips it at vector 5.
    function automatic logic model_fn(input logic [3:0] v, input int m);
        logic o;
        o = ~((v[3] & v[2]) | (v[1] ^ v[0]));
        if (m == 1) o = 1'b0;
        if (m == 2 && v == 4'd5) o = ~o;
        return o;
    endfunction

    function automatic logic [15:0] golden_table(input int m);
        logic [15:0] t;
        for (int k = 0; k < 16; k++) t[k] = model_fn(4'(k), m);
        return t;
    endfunction

    assign fn0 = model_fn(vec0, mode);
    assign fn1 = model_fn(vec1, mode);
    assign fn3 = model_fn(vec3, mode);

    combo2_sweep_ctrl #(.SETTLE_CYCLES(0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start_v[0]), .abort(1'b0), .fn_o(fn0),
        .vec_out(vec0), .busy(busy0), .done(done0), .pass(pass0),
`ifdef COMBO_SWEEP_FIRSTFAIL_EN
        .fail_valid(fv0), .first_fail_idx(ff0),
`endif
        .truth_table(tab0));

    combo2_sweep_ctrl #(.SETTLE_CYCLES(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start_v[1]), .abort(abort), .fn_o(fn1),
        .vec_out(vec1), .busy(busy1), .done(done1), .pass(pass1),
`ifdef COMBO_SWEEP_FIRSTFAIL_EN
        .fail_valid(fv1), .first_fail_idx(ff1),
`endif
        .truth_table(tab1));

    combo2_sweep_ctrl #(.SETTLE_CYCLES(3)) u_dut3 (
        .clk(clk), .rst(rst), .start(start_v[2]), .abort(1'b0), .fn_o(fn3),
        .vec_out(vec3), .busy(busy3), .done(done3), .pass(pass3),
`ifdef COMBO_SWEEP_FIRSTFAIL_EN
        .fail_valid(fv3), .first_fail_idx(ff3),
`endif
        .truth_table(tab3));

    // Observed view of whichever instance is under test.
    int          sel;
    logic [3:0]  vec_m;
    logic        busy_m, done_m, pass_m;
    logic [15:0] tab_m;
    logic        fv_m;
    logic [3:0]  ff_m;

    always_comb begin
        vec_m = vec1; busy_m = busy1; done_m = done1; pass_m = pass1; tab_m = tab1;
        fv_m = 1'b0; ff_m = 4'd0;
`ifdef COMBO_SWEEP_FIRSTFAIL_EN
        fv_m = fv1; ff_m = ff1;
`endif
        if (sel == 0) begin
            vec_m = vec0; busy_m = busy0; done_m = done0; pass_m = pass0; tab_m = tab0;
`ifdef COMBO_SWEEP_FIRSTFAIL_EN
            fv_m = fv0; ff_m = ff0;
`endif
        end else if (sel == 2) begin
            vec_m = vec3; busy_m = busy3; done_m = done3; pass_m = pass3; tab_m = tab3;
`ifdef COMBO_SWEEP_FIRSTFAIL_EN
            fv_m = fv3; ff_m = ff3;
`endif
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int settle_of(input int s);
        return (s == 0) ? 0 : ((s == 1) ? 1 : 3);
    endfunction

    // Run one sweep on instance s; optionally pulse start again at cycle restart_at.
    task automatic run_sweep(input int s, input int restart_at);
        exp_t e, got;
        int   cyc;
        bit   seen;
        logic [15:0] g;
        e.tab    = golden_table(mode);
        e.pass   = (e.tab == 16'h0999);
        e.cyc    = 16 * (2 + settle_of(s)) + 1;
        g        = golden_table(0);
        e.fvalid = 1'b0;
        e.fidx   = 4'd0;
        for (int k = 0; k < 16; k++) begin
            if (!e.fvalid && e.tab[k] != g[k]) begin
                e.fvalid = 1'b1;
                e.fidx   = 4'(k);
            end
        end
        sel = s;
        sb.push_back(e);
        @(negedge clk);
        start_v[s] = 1'b1;
        @(negedge clk);
        start_v = '0;
        cyc  = 1;
        seen = 0;
        check_eq("busy_after_start", 32'(busy_m), 32'd1);
        while (cyc <= 200 && !seen) begin
            if (done_m) begin
                seen = 1;
                if (sb.size() == 0) begin
                    check_eq("sb_empty", 32'd0, 32'd1);
                end else begin
                    got = sb.pop_front();
                    check_eq("done_cycle", 32'(cyc), 32'(got.cyc));
                    check_eq("table", 32'(tab_m), 32'(got.tab));
                    check_eq("pass", 32'(pass_m), 32'(got.pass));
                    check_eq("busy_in_done", 32'(busy_m), 32'd0);
                    check_eq("last_vec", 32'(vec_m), 32'd15);
`ifdef COMBO_SWEEP_FIRSTFAIL_EN
                    check_eq("fail_valid", 32'(fv_m), 32'(got.fvalid));
                    if (got.fvalid) check_eq("first_fail_idx", 32'(ff_m), 32'(got.fidx));
`endif
                    @(negedge clk);
                    check_eq("done_one_cycle", 32'(done_m), 32'd0);
                    check_eq("pass_held", 32'(pass_m), 32'(got.pass));
                end
            end else begin
                start_v[s] = (cyc == restart_at);
                @(negedge clk);
                cyc++;
            end
        end
        start_v = '0;
        if (!seen) check_eq("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int dcount;
        rst = 1'b1; start_v = '0; abort = 1'b0; mode = 0; sel = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_eq("rst_vec", 32'(vec1), 32'd0);
        check_eq("rst_busy", 32'(busy1), 32'd0);
        check_eq("rst_done", 32'(done1), 32'd0);
        check_eq("rst_pass", 32'(pass1), 32'd0);
        check_eq("rst_table", 32'(tab1), 32'd0);

        // Correct block at each settle time, then faulty blocks.
        run_sweep(1, 0);
        run_sweep(0, 0);
        run_sweep(2, 0);
        mode = 1; run_sweep(1, 0);
        mode = 2; run_sweep(1, 0);
        mode = 0;

        // Re-start mid-sweep must be ignored: done still lands at cycle 49.
        run_sweep(1, 10);

        // Abort 10 cycles after start lands in APPLY of vector 3.
        sel = 1;
        @(negedge clk); start_v[1] = 1'b1;
        @(negedge clk); start_v = '0;
        repeat (9) @(negedge clk);
        abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        check_eq("abort_busy", 32'(busy1), 32'd0);
        check_eq("abort_pass", 32'(pass1), 32'd0);
        check_eq("abort_vec_held", 32'(vec1), 32'd2);
        check_eq("abort_partial", 32'(tab1), 32'h0001);
        dcount = 0;
        repeat (60) begin
            @(negedge clk);
            if (done1) dcount++;
        end
        check_eq("abort_no_done", 32'(dcount), 32'd0);
        run_sweep(1, 0);

        // Reset at cycle 20 of a sweep returns everything to reset values.
        @(negedge clk); start_v[1] = 1'b1;
        @(negedge clk); start_v = '0;
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        check_eq("mid_rst_vec", 32'(vec1), 32'd0);
        check_eq("mid_rst_busy", 32'(busy1), 32'd0);
        check_eq("mid_rst_done", 32'(done1), 32'd0);
        check_eq("mid_rst_pass", 32'(pass1), 32'd0);
        check_eq("mid_rst_table", 32'(tab1), 32'd0);
        run_sweep(1, 0);

        check_eq("sb_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
